// File: rtl/param_frame_sync.sv
`default_nettype none
// ============================================================================
// Module      : param_frame_sync
// Description : Parametrised frame synchroniser. It correlates the demod bit
//               stream against a syncword that repeats up to MAX_REPS times
//               with programmable signs. A SEARCH/VERIFY/LOCKED machine uses
//               programmable lock and unlock counts, steps a phase-rotation
//               request while searching, and reports the sync-field bit
//               errors seen at each check.
// Ports       : clk, reset (sync, active high), clkEn (bit enable)
//               dataBitIn, syncWord, syncReps, repSigns, frameBits,
//               syncThreshold, lockCount, unlockCount       -> inputs
//               rotation, frameSyncState, frameSync, frameStart,
//               codewordEn, correlation, syncErrors, configError -> outputs
// Revision    : 1.0 - initial release
// ============================================================================
module param_frame_sync #(
   parameter int SYNC_BITS = 64,
   parameter int MAX_REPS  = 4,
   parameter int LEN_BITS  = 16,
   parameter int CNT_BITS  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clkEn,
   input  logic                 dataBitIn,
   input  logic [SYNC_BITS-1:0] syncWord,
   input  logic [2:0]           syncReps,
   input  logic [MAX_REPS-1:0]  repSigns,
   input  logic [LEN_BITS-1:0]  frameBits,
   input  logic signed [10:0]   syncThreshold,
   input  logic [CNT_BITS-1:0]  lockCount,
   input  logic [CNT_BITS-1:0]  unlockCount,
   output logic [1:0]           rotation,
   output logic [1:0]           frameSyncState,
   output logic                 frameSync,
   output logic                 frameStart,
   output logic                 codewordEn,
   output logic signed [17:0]   correlation,
   output logic [7:0]           syncErrors,
   output logic                 configError
);

   localparam int c_SR_BITS = SYNC_BITS * MAX_REPS;
   localparam int c_SHIFT   = 17 - $clog2(c_SR_BITS);

   localparam logic [1:0] c_SEARCH = 2'b00;
   localparam logic [1:0] c_VERIFY = 2'b01;
   localparam logic [1:0] c_LOCKED = 2'b11;

   // Registered state
   logic [c_SR_BITS-1:0] r_sr;
   logic [1:0]           r_state;
   logic [1:0]           r_rot;
   logic [LEN_BITS-1:0]  r_pos;
   logic [LEN_BITS-1:0]  r_searchCnt;
   logic [CNT_BITS-1:0]  r_hitCnt;
   logic [CNT_BITS-1:0]  r_missCnt;
   logic                 r_frameStart;
   logic                 r_cwEn;
   logic                 r_cfgErr;
   logic signed [17:0]   r_corr;
   logic [7:0]           r_syncErr;

   // Latched frame configuration
   logic [2:0]           r_reps;
   logic [MAX_REPS-1:0]  r_signs;
   logic [LEN_BITS-1:0]  r_frameBits;
   logic [CNT_BITS-1:0]  r_lockCnt;
   logic [CNT_BITS-1:0]  r_unlockCnt;

   // Combinational datapath
   logic [10:0]          w_mis [MAX_REPS];
   logic signed [10:0]   w_bitSum [MAX_REPS];
   logic signed [10:0]   w_longSum;
   logic signed [11:0]   w_ls12;
   logic signed [11:0]   w_thr12;
   logic signed [31:0]   w_corrWide;
   logic signed [17:0]   w_corrSat;
   logic [7:0]           w_syncErrSat;
   logic [31:0]          w_span;
   logic                 w_cfgErr;
   logic                 w_hit;
   logic                 w_invHit;
   logic [CNT_BITS:0]    w_hitNext;
   logic [CNT_BITS:0]    w_missNext;
   logic [CNT_BITS:0]    w_lockEff;
   logic [CNT_BITS:0]    w_unlockEff;
   logic                 w_toSearch;

   // Each repetition window is compared directly against the syncword; the
   // window k*SYNC_BITS bits back holds exactly what a bitSum delay line of
   // k*SYNC_BITS enables would hold.
   always_comb begin
      w_longSum = '0;
      for (int k = 0; k < MAX_REPS; k++) begin
         w_mis[k] = '0;
         for (int i = 0; i < SYNC_BITS; i++) begin
            w_mis[k] = w_mis[k] + 11'(r_sr[k*SYNC_BITS+i] ^ syncWord[i]);
         end
         // matches - mismatches = SYNC_BITS - 2*mismatches
         w_bitSum[k] = 11'(SYNC_BITS) - (w_mis[k] << 1);
         if (k < int'(r_reps)) begin
            w_longSum = r_signs[k] ? (w_longSum - w_bitSum[k])
                                   : (w_longSum + w_bitSum[k]);
         end
      end
   end

   assign w_span   = 32'(r_reps) * 32'(SYNC_BITS);
   assign w_cfgErr = (r_reps == 3'd0) || (32'(r_reps) > 32'(MAX_REPS)) ||
                     (32'(r_frameBits) <= w_span);

   // One extra bit so that negating the most negative threshold is exact
   assign w_ls12   = {w_longSum[10], w_longSum};
   assign w_thr12  = {syncThreshold[10], syncThreshold};
   assign w_hit    = !w_cfgErr && (w_ls12 > w_thr12);
   assign w_invHit = !w_cfgErr && !w_hit && (w_ls12 < -w_thr12);

   // Left-justify; a full-scale peak on a power-of-two window lands exactly
   // one LSB above the 18-bit positive limit, so clip instead of wrapping.
   always_comb begin
      w_corrWide = {{21{w_longSum[10]}}, w_longSum};
      w_corrWide = w_corrWide <<< c_SHIFT;
      if (w_corrWide > 32'sd131071) begin
         w_corrSat = 18'sh1FFFF;
      end else if (w_corrWide < -32'sd131072) begin
         w_corrSat = 18'sh20000;
      end else begin
         w_corrSat = w_corrWide[17:0];
      end
   end

   assign w_syncErrSat = (w_mis[0] > 11'd255) ? 8'hFF : w_mis[0][7:0];

   // A programmed count of zero behaves as one
   assign w_lockEff   = (r_lockCnt == '0)   ? (CNT_BITS+1)'(1) : {1'b0, r_lockCnt};
   assign w_unlockEff = (r_unlockCnt == '0) ? (CNT_BITS+1)'(1) : {1'b0, r_unlockCnt};
   assign w_hitNext   = {1'b0, r_hitCnt} + 1'b1;
   assign w_missNext  = {1'b0, r_missCnt} + 1'b1;

   // Leaving VERIFY on a failed check, or LOCKED on the last allowed miss
   assign w_toSearch = (r_pos == '0) && !w_hit &&
                       ((r_state == c_VERIFY) ||
                        ((r_state == c_LOCKED) && (w_missNext >= w_unlockEff)));

   always_ff @(posedge clk) begin
      if (reset || (clkEn && w_toSearch)) begin
         r_reps      <= syncReps;
         r_signs     <= repSigns;
         r_frameBits <= frameBits;
         r_lockCnt   <= lockCount;
         r_unlockCnt <= unlockCount;
      end
   end

   always_ff @(posedge clk) begin
      r_frameStart <= 1'b0;
      if (reset) begin
         r_sr        <= '0;
         r_state     <= c_SEARCH;
         r_rot       <= '0;
         r_pos       <= '0;
         r_searchCnt <= '0;
         r_hitCnt    <= '0;
         r_missCnt   <= '0;
         r_cwEn      <= 1'b0;
         r_cfgErr    <= 1'b0;
         r_corr      <= '0;
         r_syncErr   <= '0;
      end else if (clkEn) begin
         r_sr     <= {r_sr[c_SR_BITS-2:0], dataBitIn};
         r_corr   <= w_corrSat;
         r_cfgErr <= w_cfgErr;
         case (r_state)
            c_SEARCH: begin
               if (w_hit || w_invHit) begin
                  r_state     <= c_VERIFY;
                  r_hitCnt    <= CNT_BITS'(1);
                  r_pos       <= r_frameBits - 1'b1;
                  r_searchCnt <= '0;
                  r_syncErr   <= w_syncErrSat;
                  if (w_invHit) begin
                     r_rot[1] <= ~r_rot[1];
                  end
               end else if (!w_cfgErr) begin
                  // A full frame period without any hit: try the next phase
                  if (r_searchCnt == r_frameBits - 1'b1) begin
                     r_rot       <= r_rot + 2'd1;
                     r_searchCnt <= '0;
                  end else begin
                     r_searchCnt <= r_searchCnt + 1'b1;
                  end
               end
            end
            c_VERIFY: begin
               if (r_pos != '0) begin
                  r_pos <= r_pos - 1'b1;
               end else begin
                  r_pos     <= r_frameBits - 1'b1;
                  r_syncErr <= w_syncErrSat;
                  if (w_hit) begin
                     r_hitCnt <= w_hitNext[CNT_BITS-1:0];
                     if (w_hitNext >= w_lockEff) begin
                        r_state   <= c_LOCKED;
                        r_missCnt <= '0;
                     end
                  end else begin
                     r_state     <= c_SEARCH;
                     r_rot       <= r_rot + 2'd1;
                     r_searchCnt <= '0;
                     r_hitCnt    <= '0;
                  end
               end
            end
            c_LOCKED: begin
               if (r_pos != '0) begin
                  r_pos <= r_pos - 1'b1;
               end else begin
                  r_pos     <= r_frameBits - 1'b1;
                  r_syncErr <= w_syncErrSat;
                  if (w_hit) begin
                     r_missCnt    <= '0;
                     r_frameStart <= 1'b1;
                     r_cwEn       <= 1'b1;
                  end else begin
                     r_missCnt <= w_missNext[CNT_BITS-1:0];
                     r_cwEn    <= 1'b0;
                     if (w_toSearch) begin
                        r_state     <= c_SEARCH;
                        r_searchCnt <= '0;
                        r_missCnt   <= '0;
                        r_hitCnt    <= '0;
                     end
                  end
               end
            end
            default: begin
               r_state <= c_SEARCH;
            end
         endcase
      end
   end

   assign rotation       = r_rot;
   assign frameSyncState = r_state;
   assign frameSync      = (r_state == c_LOCKED);
   assign frameStart     = r_frameStart;
   assign codewordEn     = r_cwEn;
   assign correlation    = r_corr;
   assign syncErrors     = r_syncErr;
   assign configError    = r_cfgErr;

endmodule
`default_nettype wire

// File: tb/tb_param_frame_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_frame_sync
// Description : Directed self-checking bench for param_frame_sync. Frames are
//               built from the CCSDS 64-bit attached sync marker plus random
//               payload; expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_frame_sync;

   localparam logic [63:0] c_SYNC = 64'h034776C7272895B0;
   // Five flipped bits: 63, 32, 20, 10, 0
   localparam logic [63:0] c_ERR5 = 64'h8000_0001_0010_0401;

   logic               clk = 1'b0;
   logic               reset;
   logic               clkEn;
   logic               dataBitIn;
   logic [63:0]        syncWord;
   logic [2:0]         syncReps;
   logic [3:0]         repSigns;
   logic [15:0]        frameBits;
   logic signed [10:0] syncThreshold;
   logic [3:0]         lockCount;
   logic [3:0]         unlockCount;
   logic [1:0]         rotation;
   logic [1:0]         frameSyncState;
   logic               frameSync;
   logic               frameStart;
   logic               codewordEn;
   logic signed [17:0] correlation;
   logic [7:0]         syncErrors;
   logic               configError;

   int n_checks = 0;
   int n_errors = 0;

   param_frame_sync #(
      .SYNC_BITS (64),
      .MAX_REPS  (4),
      .LEN_BITS  (16),
      .CNT_BITS  (4)
   ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .clkEn          (clkEn),
      .dataBitIn      (dataBitIn),
      .syncWord       (syncWord),
      .syncReps       (syncReps),
      .repSigns       (repSigns),
      .frameBits      (frameBits),
      .syncThreshold  (syncThreshold),
      .lockCount      (lockCount),
      .unlockCount    (unlockCount),
      .rotation       (rotation),
      .frameSyncState (frameSyncState),
      .frameSync      (frameSync),
      .frameStart     (frameStart),
      .codewordEn     (codewordEn),
      .correlation    (correlation),
      .syncErrors     (syncErrors),
      .configError    (configError)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      dataBitIn = b;
      clkEn     = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [63:0] w);
      for (int i = 63; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic send_random(input int n);
      logic [31:0] rv;
      for (int i = 0; i < n; i++) begin
         rv = $urandom();
         send_bit(rv[0]);
      end
   endtask

   task automatic set_cfg(input logic [2:0] reps, input logic [3:0] signs, input logic [15:0] fb,
                          input int thr, input logic [3:0] lk, input logic [3:0] ulk);
      syncReps      = reps;
      repSigns      = signs;
      frameBits     = fb;
      syncThreshold = 11'(thr);
      lockCount     = lk;
      unlockCount   = ulk;
   endtask

   task automatic do_reset();
      clkEn = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Four-field multi-repetition pattern, oldest first: k3 +, k2 -, k1 +, k0 +
   task automatic send_multi();
      send_word(c_SYNC);
      send_word(~c_SYNC);
      send_word(c_SYNC);
      send_word(c_SYNC);
   endtask

   initial begin
      reset     = 1'b1;
      clkEn     = 1'b0;
      dataBitIn = 1'b0;
      syncWord  = c_SYNC;

      // ---- Acquisition, lock, bit errors and loss of lock ----
      set_cfg(3'd1, 4'b0000, 16'd2112, 48, 4'd3, 4'd3);
      do_reset();
      check_val("rst_state",  32'(frameSyncState), 32'd0);
      check_val("rst_rot",    32'(rotation),       32'd0);
      check_val("rst_sync",   32'(frameSync),      32'd0);
      check_val("rst_fs",     32'(frameStart),     32'd0);
      check_val("rst_cw",     32'(codewordEn),     32'd0);
      check_val("rst_corr",   32'(correlation),    32'd0);
      check_val("rst_serr",   32'(syncErrors),     32'd0);
      check_val("rst_cfgerr", 32'(configError),    32'd0);

      send_random(100);
      send_word(c_SYNC); send_random(2048);
      check_val("f1_state", 32'(frameSyncState), 32'd1);
      send_word(c_SYNC); send_random(2048);
      check_val("f2_state", 32'(frameSyncState), 32'd1);
      send_word(c_SYNC); send_random(2048);
      check_val("f3_state", 32'(frameSyncState), 32'd3);
      check_val("f3_sync",  32'(frameSync),      32'd1);

      send_word(c_SYNC); send_random(1);
      check_val("f4_fs",   32'(frameStart),  32'd1);
      check_val("f4_cw",   32'(codewordEn),  32'd1);
      check_val("f4_corr", 32'(correlation), 32'd32768);
      check_val("f4_serr", 32'(syncErrors),  32'd0);
      send_random(1);
      check_val("f4_fs_pulse", 32'(frameStart), 32'd0);
      send_random(2046);

      send_word(c_SYNC ^ c_ERR5); send_random(1);
      check_val("f5_fs",    32'(frameStart),     32'd1);
      check_val("f5_state", 32'(frameSyncState), 32'd3);
      check_val("f5_serr",  32'(syncErrors),     32'd5);
      send_random(2047);

      send_random(64); send_random(2048);
      check_val("f6_state", 32'(frameSyncState), 32'd3);
      check_val("f6_cw",    32'(codewordEn),     32'd0);
      send_random(64); send_random(2048);
      check_val("f7_state", 32'(frameSyncState), 32'd3);
      send_random(64); send_random(2048);
      check_val("f8_state", 32'(frameSyncState), 32'd0);
      check_val("f8_sync",  32'(frameSync),      32'd0);
      check_val("f8_rot",   32'(rotation),       32'd0);

      // ---- Inverted stream: first hit inverted, then normal hits lock ----
      do_reset();
      send_random(37);
      send_word(~c_SYNC); send_random(2048);
      check_val("inv_state", 32'(frameSyncState), 32'd1);
      check_val("inv_rot",   32'(rotation),       32'd2);
      send_word(c_SYNC); send_random(2048);
      send_word(c_SYNC); send_random(2048);
      check_val("inv_lock",  32'(frameSyncState), 32'd3);
      check_val("inv_rot2",  32'(rotation),       32'd2);

      // ---- No sync: rotation steps every frame period ----
      do_reset();
      send_random(2111);
      check_val("rot_before", 32'(rotation), 32'd0);
      send_random(1);
      check_val("rot_1", 32'(rotation), 32'd1);
      send_random(2112);
      check_val("rot_2", 32'(rotation), 32'd2);
      send_random(2112);
      check_val("rot_3", 32'(rotation), 32'd3);
      send_random(2112);
      check_val("rot_wrap",  32'(rotation),       32'd0);
      check_val("rot_state", 32'(frameSyncState), 32'd0);

      // ---- Four signed repetitions, lockCount 0 behaves as 1 ----
      set_cfg(3'd4, 4'b0100, 16'd8192, 200, 4'd0, 4'd3);
      do_reset();
      send_multi(); send_random(1);
      // longSum peak 256 left-justified by 9 clips to the 18-bit maximum
      check_val("rep_corr",  32'(correlation),    32'd131071);
      check_val("rep_state", 32'(frameSyncState), 32'd1);
      send_random(7935);
      send_multi(); send_random(7936);
      check_val("rep_lock",  32'(frameSyncState), 32'd3);

      set_cfg(3'd4, 4'b0000, 16'd8192, 200, 4'd0, 4'd3);
      do_reset();
      send_multi(); send_random(1);
      check_val("rep0_corr",  32'(correlation),    32'd65536);
      send_random(7935);
      check_val("rep0_state", 32'(frameSyncState), 32'd0);
      check_val("rep0_rot",   32'(rotation),       32'd1);

      // ---- Configuration errors ----
      set_cfg(3'd2, 4'b0000, 16'd100, 48, 4'd3, 4'd3);
      do_reset();
      send_random(50); send_word(c_SYNC); send_word(c_SYNC); send_random(200);
      check_val("cfg100_err",   32'(configError),    32'd1);
      check_val("cfg100_state", 32'(frameSyncState), 32'd0);
      check_val("cfg100_rot",   32'(rotation),       32'd0);
      set_cfg(3'd2, 4'b0000, 16'd128, 48, 4'd3, 4'd3);
      do_reset(); send_random(2);
      check_val("cfg128_err", 32'(configError), 32'd1);
      set_cfg(3'd2, 4'b0000, 16'd129, 48, 4'd3, 4'd3);
      do_reset(); send_random(2);
      check_val("cfg129_ok", 32'(configError), 32'd0);
      set_cfg(3'd0, 4'b0000, 16'd2112, 48, 4'd3, 4'd3);
      do_reset(); send_random(2);
      check_val("cfg_reps0", 32'(configError), 32'd1);
      set_cfg(3'd5, 4'b0000, 16'd2112, 48, 4'd3, 4'd3);
      do_reset(); send_random(2);
      check_val("cfg_reps5", 32'(configError), 32'd1);

      // ---- Short frames, lockCount 1, clkEn low, reset mid-LOCKED ----
      set_cfg(3'd1, 4'b0000, 16'd129, 48, 4'd1, 4'd2);
      do_reset();
      send_word(~c_SYNC); send_random(65);
      check_val("s_verify", 32'(frameSyncState), 32'd1);
      check_val("s_rot",    32'(rotation),       32'd2);
      send_word(c_SYNC); send_random(65);
      check_val("s_lock",   32'(frameSyncState), 32'd3);
      send_word(c_SYNC); send_random(1);
      check_val("s_fs",     32'(frameStart),     32'd1);
      clkEn = 1'b0;
      @(posedge clk);
      #1;
      check_val("hold_fs",    32'(frameStart),     32'd0);
      check_val("hold_state", 32'(frameSyncState), 32'd3);
      check_val("hold_cw",    32'(codewordEn),     32'd1);
      check_val("hold_corr",  32'(correlation),    32'd32768);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_val("mr_state", 32'(frameSyncState), 32'd0);
      check_val("mr_rot",   32'(rotation),       32'd0);
      check_val("mr_sync",  32'(frameSync),      32'd0);
      check_val("mr_cw",    32'(codewordEn),     32'd0);
      check_val("mr_corr",  32'(correlation),    32'd0);
      check_val("mr_serr",  32'(syncErrors),     32'd0);
      check_val("mr_cfg",   32'(configError),    32'd0);
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
